// File: rtl/spike_activity_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : spike_activity_monitor
//  Purpose  : N-channel spike monitor with saturating totals, fixed-window
//             rate snapshots and a pre->post spike latency measurement.
//  Revision : 1.0  initial release
// ============================================================================
module spike_activity_monitor #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 16,
  parameter int WIN_CYC = 1000,
  parameter int LAT_W   = 12,
  parameter int SEL_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_i,
  input  logic              clear_i,
  input  logic [N_CH-1:0]   spike_in_i,
  input  logic [SEL_W-1:0]  pre_sel_i,
  input  logic [SEL_W-1:0]  post_sel_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_total_o,
  output logic [CNT_W-1:0]  rd_rate_o,
  output logic              win_valid_o,
  output logic [LAT_W-1:0]  lat_out_o,
  output logic              lat_valid_o,
  output logic              lat_timeout_o
);

  localparam int              TMR_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [LAT_W-1:0] LAT_MAX  = '1;
  localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WIN_CYC - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } lat_state_t;

  logic                   srst;
  logic [N_CH-1:0]        prev_q;
  logic [N_CH-1:0]        spk_edge;
  logic [TMR_W-1:0]       wtmr_q;
  logic                   win_end;
  logic                   win_valid_q;
  logic [N_CH*CNT_W-1:0]  total_flat;
  logic [N_CH*CNT_W-1:0]  rate_flat;
  logic                   pre_hit;
  logic                   post_hit;
  lat_state_t             state_q;
  logic [LAT_W-1:0]       lat_t_q;
  logic [LAT_W-1:0]       lat_k;
  logic [LAT_W-1:0]       lat_out_q;
  logic                   lat_valid_q;
  logic                   lat_timeout_q;

  // Soft clear behaves exactly like reset
  assign srst     = rst | clear_i;
  // Rising edges only count while the monitor is enabled
  assign spk_edge = spike_in_i & ~prev_q & {N_CH{ena_i}};
  assign win_end  = ena_i & (wtmr_q == WIN_LAST);
  // Enabled cycles elapsed since arming, including the current one
  assign lat_k    = lat_t_q + 1'b1;

  // Previous-sample registers track the input even while disabled
  always_ff @(posedge clk) begin
    if (srst) prev_q <= '0;
    else      prev_q <= spike_in_i;
  end

  // Window timer advances on enabled cycles and flags each completed window
  always_ff @(posedge clk) begin
    if (srst) begin
      wtmr_q      <= '0;
      win_valid_q <= 1'b0;
    end else begin
      win_valid_q <= win_end;
      if (win_end)    wtmr_q <= '0;
      else if (ena_i) wtmr_q <= wtmr_q + 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [CNT_W-1:0] total_q;
      logic [CNT_W-1:0] total_d;
      logic [CNT_W-1:0] win_q;
      logic [CNT_W-1:0] win_d;
      logic [CNT_W-1:0] rate_q;

      // Saturating increments for this channel's total and window counts
      always_comb begin
        total_d = total_q;
        win_d   = win_q;
        if (spk_edge[i] && (total_q != CNT_MAX)) total_d = total_q + 1'b1;
        if (spk_edge[i] && (win_q   != CNT_MAX)) win_d   = win_q + 1'b1;
      end

      // Counter update; the window snapshot includes an edge in its last cycle
      always_ff @(posedge clk) begin
        if (srst) begin
          total_q <= '0;
          win_q   <= '0;
          rate_q  <= '0;
        end else begin
          total_q <= total_d;
          if (win_end) begin
            rate_q <= win_d;
            win_q  <= '0;
          end else begin
            win_q  <= win_d;
          end
        end
      end

      assign total_flat[i*CNT_W +: CNT_W] = total_q;
      assign rate_flat[i*CNT_W +: CNT_W]  = rate_q;
    end
  endgenerate

  // Readout mux; out-of-range selects read as zero
  always_comb begin
    rd_total_o = '0;
    rd_rate_o  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        rd_total_o = total_flat[i*CNT_W +: CNT_W];
        rd_rate_o  = rate_flat[i*CNT_W +: CNT_W];
      end
    end
  end

  // Pre/post edge selection; out-of-range selects never see an edge
  always_comb begin
    pre_hit  = 1'b0;
    post_hit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (pre_sel_i  == SEL_W'(i)) pre_hit  = spk_edge[i];
      if (post_sel_i == SEL_W'(i)) post_hit = spk_edge[i];
    end
  end

  // Latency FSM: nearest-pre pairing, frozen while disabled
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= S_IDLE;
      lat_t_q       <= '0;
      lat_out_q     <= '0;
      lat_valid_q   <= 1'b0;
      lat_timeout_q <= 1'b0;
    end else begin
      lat_valid_q   <= 1'b0;
      lat_timeout_q <= 1'b0;
      if (ena_i) begin
        case (state_q)
          S_IDLE: begin
            if (pre_hit && post_hit) begin
              lat_out_q   <= '0;
              lat_valid_q <= 1'b1;
            end else if (pre_hit) begin
              state_q <= S_ARMED;
              lat_t_q <= '0;
            end
          end
          S_ARMED: begin
            if (post_hit) begin
              lat_out_q   <= lat_k;
              lat_valid_q <= 1'b1;
              lat_t_q     <= '0;
              if (!pre_hit) state_q <= S_IDLE;
            end else if (pre_hit) begin
              lat_t_q <= '0;
            end else if (lat_k == LAT_MAX) begin
              lat_timeout_q <= 1'b1;
              state_q       <= S_IDLE;
            end else begin
              lat_t_q <= lat_k;
            end
          end
        endcase
      end
    end
  end

  assign win_valid_o   = win_valid_q;
  assign lat_out_o     = lat_out_q;
  assign lat_valid_o   = lat_valid_q;
  assign lat_timeout_o = lat_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_activity_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spike_activity_monitor
//  Purpose  : Self-checking bench for spike_activity_monitor
//  Revision : 1.0  initial release
// ============================================================================
module tb_spike_activity_monitor;

  localparam int N_CH    = 2;
  localparam int CNT_W   = 16;
  localparam int WIN_CYC = 1000;
  localparam int LAT_W   = 12;
  localparam int SEL_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int LMAX    = (1 << LAT_W) - 1;
  localparam int CMAX_S  = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ena = 1'b1;
  logic             clear = 1'b0;
  logic [N_CH-1:0]  spk = '0;
  logic [SEL_W-1:0] pre_sel = 4'd15;
  logic [SEL_W-1:0] post_sel = 4'd15;
  logic [SEL_W-1:0] rd_sel = 4'd0;

  logic [CNT_W-1:0] rd_total, rd_rate;
  logic             win_valid, lat_valid, lat_timeout;
  logic [LAT_W-1:0] lat_out;

  logic [3:0]       rd_total_s, rd_rate_s, lat_out_s;
  logic             win_valid_s, lat_valid_s, lat_timeout_s;

  always #5 clk = ~clk;

  spike_activity_monitor #(
    .N_CH(N_CH), .CNT_W(CNT_W), .WIN_CYC(WIN_CYC), .LAT_W(LAT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .ena_i(ena), .clear_i(clear), .spike_in_i(spk),
    .pre_sel_i(pre_sel), .post_sel_i(post_sel), .rd_sel_i(rd_sel),
    .rd_total_o(rd_total), .rd_rate_o(rd_rate), .win_valid_o(win_valid),
    .lat_out_o(lat_out), .lat_valid_o(lat_valid), .lat_timeout_o(lat_timeout)
  );

  // Narrow-counter instance sharing all inputs, used for saturation
  spike_activity_monitor #(
    .N_CH(N_CH), .CNT_W(4), .WIN_CYC(8), .LAT_W(4), .SEL_W(SEL_W)
  ) dut_s (
    .clk(clk), .rst(rst), .ena_i(ena), .clear_i(clear), .spike_in_i(spk),
    .pre_sel_i(pre_sel), .post_sel_i(post_sel), .rd_sel_i(rd_sel),
    .rd_total_o(rd_total_s), .rd_rate_o(rd_rate_s), .win_valid_o(win_valid_s),
    .lat_out_o(lat_out_s), .lat_valid_o(lat_valid_s), .lat_timeout_o(lat_timeout_s)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: plain integers and absolute cycle stamps
  int m_total[N_CH];
  int m_total_s[N_CH];
  int m_win[N_CH];
  int m_rate[N_CH];
  bit m_prev[N_CH];
  int m_en_cnt;
  bit m_armed;
  int m_arm_at;
  int m_lat;
  bit e_wv, e_lv, e_to;

  typedef struct {
    logic [SEL_W-1:0] sel;
    int               exp_total;
    int               exp_rate;
  } rd_vec_t;

  rd_vec_t rd_tab[4];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit e[N_CH];
    bit pre, post;
    int k;
    e_wv = 1'b0; e_lv = 1'b0; e_to = 1'b0;
    if (rst || clear) begin
      for (int i = 0; i < N_CH; i++) begin
        m_total[i] = 0; m_total_s[i] = 0; m_win[i] = 0; m_rate[i] = 0; m_prev[i] = 1'b0;
      end
      m_en_cnt = 0; m_armed = 1'b0; m_arm_at = 0; m_lat = 0;
      return;
    end
    for (int i = 0; i < N_CH; i++) begin
      e[i] = spk[i] && !m_prev[i] && ena;
      m_prev[i] = spk[i];
      if (e[i]) begin
        m_total[i]   = min_i(m_total[i] + 1, CMAX);
        m_total_s[i] = min_i(m_total_s[i] + 1, CMAX_S);
        m_win[i]     = min_i(m_win[i] + 1, CMAX);
      end
    end
    if (!ena) return;
    if ((m_en_cnt % WIN_CYC) == WIN_CYC - 1) begin
      for (int i = 0; i < N_CH; i++) begin
        m_rate[i] = m_win[i];
        m_win[i]  = 0;
      end
      e_wv = 1'b1;
    end
    m_en_cnt++;
    pre  = (int'(pre_sel)  < N_CH) ? e[pre_sel]  : 1'b0;
    post = (int'(post_sel) < N_CH) ? e[post_sel] : 1'b0;
    if (!m_armed) begin
      if (pre && post) begin
        m_lat = 0; e_lv = 1'b1;
      end else if (pre) begin
        m_armed = 1'b1; m_arm_at = m_en_cnt;
      end
    end else begin
      k = m_en_cnt - m_arm_at;
      if (post) begin
        m_lat = k; e_lv = 1'b1;
        if (pre) m_arm_at = m_en_cnt;
        else     m_armed  = 1'b0;
      end else if (pre) begin
        m_arm_at = m_en_cnt;
      end else if (k == LMAX) begin
        e_to = 1'b1; m_armed = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    int exp_t, exp_r, exp_ts;
    exp_t  = (int'(rd_sel) < N_CH) ? m_total[rd_sel]   : 0;
    exp_r  = (int'(rd_sel) < N_CH) ? m_rate[rd_sel]    : 0;
    exp_ts = (int'(rd_sel) < N_CH) ? m_total_s[rd_sel] : 0;
    chk("win_valid",    32'(win_valid),   32'(e_wv));
    chk("lat_valid",    32'(lat_valid),   32'(e_lv));
    chk("lat_timeout",  32'(lat_timeout), 32'(e_to));
    chk("lat_out",      32'(lat_out),     32'(m_lat));
    chk("rd_total",     32'(rd_total),    32'(exp_t));
    chk("rd_rate",      32'(rd_rate),     32'(exp_r));
    chk("rd_total_sat", 32'(rd_total_s),  32'(exp_ts));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [N_CH-1:0] m);
    spk = m;
    tick();
    spk = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rd_tab[0] = '{4'd0,  1, 0};
    rd_tab[1] = '{4'd1,  0, 0};
    rd_tab[2] = '{4'd2,  0, 0};
    rd_tab[3] = '{4'd15, 0, 0};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rd_total",    32'(rd_total),    0);
    chk("rst_lat_out",     32'(lat_out),     0);
    chk("rst_win_valid",   32'(win_valid),   0);
    chk("rst_lat_valid",   32'(lat_valid),   0);
    chk("rst_lat_timeout", 32'(lat_timeout), 0);

    // Single 3-cycle pulse on ch0 counts once
    spk = 2'b01;
    idle(3);
    spk = '0;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      rd_sel = rd_tab[i].sel;
      #1;
      chk("tab_rd_total", 32'(rd_total), 32'(rd_tab[i].exp_total));
      chk("tab_rd_rate",  32'(rd_rate),  32'(rd_tab[i].exp_rate));
    end

    // 20 pulses on ch1 inside the first window after a clear
    rd_sel = 4'd1;
    do_clear();
    for (int p = 0; p < 20; p++) begin
      pulse(2'b10);
      idle(1);
    end
    idle(959);
    chk("win_before_end", 32'(win_valid), 0);
    chk("rate_before_end", 32'(rd_rate), 0);
    idle(1);
    chk("win_at_1000", 32'(win_valid), 1);
    chk("rate_win1", 32'(rd_rate), 20);
    chk("sat_total_cnt4", 32'(rd_total_s), 15);
    idle(1);
    chk("win_pulse_one_cycle", 32'(win_valid), 0);
    idle(999);
    chk("win_at_2000", 32'(win_valid), 1);
    chk("rate_win2", 32'(rd_rate), 0);
    chk("total_kept", 32'(rd_total), 20);

    // Latency 50, then re-arm giving 20
    pre_sel = 4'd0;
    post_sel = 4'd1;
    pulse(2'b01);
    idle(49);
    pulse(2'b10);
    chk("lat50_valid", 32'(lat_valid), 1);
    chk("lat50_out", 32'(lat_out), 50);
    pulse(2'b01);
    idle(9);
    pulse(2'b01);
    idle(19);
    pulse(2'b10);
    chk("lat20_valid", 32'(lat_valid), 1);
    chk("lat20_out", 32'(lat_out), 20);

    // Timeout after 4095 enabled cycles, lat_out retained
    pulse(2'b01);
    idle(LMAX - 1);
    chk("to_early", 32'(lat_timeout), 0);
    idle(1);
    chk("to_pulse", 32'(lat_timeout), 1);
    chk("to_lat_kept", 32'(lat_out), 20);
    idle(1);
    chk("to_one_cycle", 32'(lat_timeout), 0);

    // Simultaneous pre and post in IDLE
    pulse(2'b11);
    chk("same_valid", 32'(lat_valid), 1);
    chk("same_out", 32'(lat_out), 0);
    idle(2);

    // ena low for 100 cycles mid-window with input held high
    rd_sel = 4'd0;
    do_clear();
    idle(500);
    ena = 1'b0;
    spk = 2'b01;
    idle(100);
    ena = 1'b1;
    idle(499);
    chk("frz_win_early", 32'(win_valid), 0);
    idle(1);
    chk("frz_win_shift", 32'(win_valid), 1);
    chk("frz_no_edge", 32'(rd_total), 0);
    spk = '0;
    idle(2);

    // Clear while a measurement is armed
    pulse(2'b01);
    idle(5);
    do_clear();
    idle(3);
    pulse(2'b10);
    chk("clr_no_valid", 32'(lat_valid), 0);
    chk("clr_lat_out", 32'(lat_out), 0);
    chk("clr_total", 32'(rd_total), 0);
    idle(2);

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N_CH; i++) spk[i] = ($urandom_range(0, 3) == 0);
      ena   = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 49) == 0) begin
        pre_sel  = SEL_W'($urandom_range(0, 3));
        post_sel = SEL_W'($urandom_range(0, 3));
      end
      rd_sel = ($urandom_range(0, 7) == 0) ? SEL_W'($urandom) : SEL_W'($urandom_range(0, N_CH - 1));
      tick();
    end
    clear = 1'b0;
    spk = '0;
    ena = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_activity_monitor.md
Name: spike_activity_monitor

Overview:
- Synthesizable N-channel spike monitor for the HH/STDP neuron array; successor to the two-neuron spike counting done off-chip.
- Per-channel saturating total counts, fixed-window rate snapshots, and a pre→post spike latency measurement on selectable channels.
- Sits beside the neuron array; consumes the neurons' spike flags and exposes results for readout.

Parameters:
- N_CH, 2, number of spike channels (≥2)
- CNT_W, 16, width of total and window counters
- WIN_CYC, 1000, rate window length in clock cycles (≥2)
- LAT_W, 12, latency timer width
- SEL_W, 4, width of channel-select inputs (2^SEL_W ≥ N_CH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ena  in  1  monitor enable
- clear  in  1  synchronous soft clear; same effect as rst
- spike_in  in  N_CH  per-channel spike level
- pre_sel  in  SEL_W  channel index used as the presynaptic channel
- post_sel  in  SEL_W  channel index used as the postsynaptic channel
- rd_sel  in  SEL_W  readout channel index
- rd_total  out  CNT_W  total edge count of channel rd_sel
- rd_rate  out  CNT_W  last completed window count of channel rd_sel
- win_valid  out  1  one-cycle pulse when a window completes
- lat_out  out  LAT_W  last measured pre→post latency, in enabled cycles
- lat_valid  out  1  one-cycle pulse when lat_out updates
- lat_timeout  out  1  one-cycle pulse when an armed measurement expires

Behaviour:
- Reset/clear: all counters, rate registers, prev-sample registers, window timer, lat_out, and FSM go to 0/IDLE. win_valid, lat_valid, and lat_timeout are 0. rst and clear are ORed.
- Edge detect: prev[i] registers spike_in[i] every cycle, regardless of ena. edge[i] = spike_in[i] & ~prev[i] & ena. A level held high for many cycles counts once. Input already high on the first cycle after reset counts as an edge.
- Counting: on each edge[i], total[i] and win[i] increment at that clock edge and are visible the next cycle. total saturates at 2^CNT_W-1, with no wrap. win saturates the same way.
- Window: the timer counts enabled cycles 0..WIN_CYC-1 and is frozen while ena=0.
  - On the enabled cycle where timer = WIN_CYC-1: rate[i] ← win[i] (including any edge in that cycle), win[i] ← 0, timer ← 0.
  - win_valid is high for the following cycle.
- Readout: rd_total and rd_rate are combinational muxes of the registers. rd_sel ≥ N_CH reads 0.
- Latency FSM, states IDLE and ARMED. pre = edge[pre_sel], post = edge[post_sel]. Either selector ≥ N_CH is treated as no edge.
  - IDLE, pre & post in the same cycle: lat_out ← 0, lat_valid pulse; stay IDLE.
  - IDLE, pre only: go to ARMED, timer t ← 0.
  - ARMED, each enabled cycle: t ← t+1. A post arriving k enabled cycles after the arming pre sets lat_out ← k and pulses lat_valid.
    - If pre arrives in the same cycle as that post, re-arm (ARMED, t ← 0). Otherwise go to IDLE.
  - ARMED, pre without post: re-arm with t ← 0 (nearest-pre pairing).
  - ARMED, k reaches 2^LAT_W-1 with no post: lat_timeout pulse, go to IDLE, lat_out unchanged.
  - ena=0 freezes t and the FSM.
  - pre_sel = post_sel: every edge reports latency 0 (same-cycle rule).
- Pulse outputs are registered: high for exactly the one cycle after the triggering clock edge.
- Changing pre_sel/post_sel while ARMED applies from the next cycle. The running measurement is not aborted.

Test Plan:
- Reset, then a single 3-cycle pulse on ch0 → rd_sel=0 gives rd_total=1; ch1 total=0; all pulse outputs 0.
- WIN_CYC=1000, 20 single-cycle pulses on ch1 inside the first window → win_valid pulses once at cycle 1000; rd_rate(ch1)=20; next window with no spikes → rd_rate(ch1)=0, total stays 20.
- pre_sel=0, post_sel=1; ch0 edge, then ch1 edge 50 cycles later → lat_out=50, one lat_valid pulse. Second ch0 edge at +10 then ch1 edge at +30 → lat_out=20 (re-arm).
- ch0 edge with no ch1 edge, LAT_W=12 → lat_timeout after 4095 enabled cycles; lat_out keeps its previous value.
- ch0 and ch1 rise in the same cycle in IDLE → lat_out=0. ena=0 for 100 cycles mid-window → timer frozen, edges ignored, no false edge on re-enable with input held high.
- CNT_W=4, 20 edges → rd_total=15. clear asserted mid-measurement → all counts 0, FSM IDLE, no lat_valid.
